// File: rtl/pipe_muldiv.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers for the EX stage.
// One result bit per cycle: 1 latch cycle, 32 iterate cycles, 1 fix-up cycle.
//
// state | meaning
// IDLE  | no operation pending; mthi/mtlo accepted; start latches operands
// CALC  | 32 shift-add (mult) or restoring shift-subtract (div) iterations
// FIX   | apply sign correction / divide-by-zero override, write HI/LO
module pipe_muldiv (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hilo,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state_q, state_d;
  logic        div_q, div_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] araw_q, araw_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        op_signed;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_rsh;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign op_signed = ~op[0];
  assign a_mag     = (op_signed & a[31]) ? (~a + 32'd1) : a;
  assign b_mag     = (op_signed & b[31]) ? (~b + 32'd1) : b;

  // Multiply: add multiplicand into the upper half, shift the whole product right.
  assign mul_sum   = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);

  // Divide: bring in the next dividend bit, subtract the divisor if it fits.
  assign div_rsh   = {acc_q[63:32], a_q[31]};
  assign div_ge    = (div_rsh >= {1'b0, b_q});
  assign div_sub   = div_rsh[31:0] - b_q;

  assign prod_fix  = qneg_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix   = qneg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix   = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    a_d     = a_q;
    b_d     = b_q;
    araw_d  = araw_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = wdata;
        if (wr_lo) lo_d = wdata;
        if (start) begin
          div_d   = op[1];
          a_d     = a_mag;
          b_d     = b_mag;
          araw_d  = a;
          qneg_d  = op_signed & (a[31] ^ b[31]);
          rneg_d  = op_signed & a[31];
          dz_d    = (b == 32'd0);
          acc_d   = 64'd0;
          cnt_d   = 5'd0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (!div_q) begin
          acc_d = {mul_sum, acc_q[31:1]};
          b_d   = {1'b0, b_q[31:1]};
        end else begin
          acc_d = {(div_ge ? div_sub : div_rsh[31:0]), acc_q[30:0], div_ge};
          a_d   = {a_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end

      S_FIX: begin
        if (!div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (dz_q) begin
          hi_d = araw_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      araw_q  <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      a_q     <= a_d;
      b_q     <= b_d;
      araw_q  <= araw_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (start | rd_hilo | wr_hi | wr_lo);

endmodule
